// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared types and constants for dram_arbiter
package dram_arb_pkg;

  localparam int         NUM_REQ   = 2;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - 2-way round-robin grant; the requester not granted last wins a tie
module rr_arbiter
  import dram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_last,
  output logic [NUM_REQ-1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    if (i_req[0] && i_req[1]) begin
      o_grant = i_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - shares one AXI4-Lite master between two requesters, one transfer in flight
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [DATA_W-1:0]           req_rdata,
  output logic                        req_err,
  output logic [ADDR_W-1:0]           M_AXI_AWADDR,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [DATA_W-1:0]           M_AXI_WDATA,
  output logic [DATA_W/8-1:0]         M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [ADDR_W-1:0]           M_AXI_ARADDR,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [DATA_W-1:0]           M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  localparam int STRB_W = DATA_W / 8;

  state_t              r_state;
  logic                r_gnt;
  logic                r_last;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic [NUM_REQ-1:0]  r_req_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic [ADDR_W-1:0]   r_araddr;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;

  logic [NUM_REQ-1:0]  w_grant;
  logic                w_idx;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [STRB_W-1:0]   w_wstrb;
  logic                w_aw_done;
  logic                w_w_done;

  rr_arbiter u_rr (
    .i_req   (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  assign w_idx   = w_grant[1];
  assign w_addr  = w_idx ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
  assign w_wdata = w_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign w_wstrb = w_idx ? req_wstrb[2*STRB_W-1:STRB_W] : req_wstrb[STRB_W-1:0];

  // A write channel counts as finished if it already handshook or handshakes this cycle
  assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= IDLE;
      r_gnt       <= 1'b0;
      r_last      <= 1'b1;
      r_req_ready <= '0;
      r_req_done  <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
    end else begin
      r_req_ready <= '0;
      r_req_done  <= '0;
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_gnt       <= w_idx;
            r_last      <= w_idx;
            r_req_ready <= w_grant;
            if (req_we[w_idx]) begin
              r_awaddr  <= w_addr;
              r_wdata   <= w_wdata;
              r_wstrb   <= w_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_ADDR;
            end else begin
              r_araddr  <= w_addr;
              r_arvalid <= 1'b1;
              r_state   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (M_AXI_RVALID) begin
            r_rready   <= 1'b0;
            r_rdata    <= M_AXI_RDATA;
            r_err      <= (M_AXI_RRESP != RESP_OKAY);
            r_req_done <= idx_onehot(r_gnt);
            r_state    <= IDLE;
          end
        end
        WR_ADDR: begin
          if (M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            r_bready   <= 1'b0;
            r_err      <= (M_AXI_BRESP != RESP_OKAY);
            r_req_done <= idx_onehot(r_gnt);
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign req_done      = r_req_done;
  assign req_rdata     = r_rdata;
  assign req_err       = r_err;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule
